// File: rtl/sha_pkg.sv
// Shared width constants for the adder and subtractor datapaths.
package sha_pkg;

    localparam int unsigned ADD_WIDTH = 32;
    localparam int unsigned ADD_SLICE = 8;

    // Pipelined subtractor: WIDTH must be a multiple of SLICE, at least two slices.
    localparam int unsigned SUB_WIDTH = 32;
    localparam int unsigned SUB_SLICE = 8;

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract slice with borrow in and borrow out.
module sub_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] full;

    // The extra top bit goes to 1 exactly when the slice result is negative.
    assign full     = (W+1)'(a_i) - (W+1)'(b_i) - (W+1)'(borrow_i);
    assign diff_o   = full[W-1:0];
    assign borrow_o = full[W];

endmodule

// File: rtl/sub_32b_pipe.sv
// Slice-pipelined subtractor: one SLICE-bit slice per stage, valid/ready at both ends.
module sub_32b_pipe
    import sha_pkg::*;
#(
    parameter int unsigned WIDTH = SUB_WIDTH,
    parameter int unsigned SLICE = SUB_SLICE
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_borrow,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow
);

    localparam int unsigned N = WIDTH / SLICE;

    logic             en;
    logic [N-1:0]     vld_q;
    logic [N-1:0]     brw_q;
    logic [N-1:0]     brw_d;
    logic [WIDTH-1:0] d_q [N];
    logic [WIDTH-1:0] d_d [N];
    logic [WIDTH-1:0] a_q [N-1];
    logic [WIDTH-1:0] b_q [N-1];

    // The whole pipe moves together; it only freezes when a result is held.
    assign en      = !vld_q[N-1] || i_ready;
    assign o_ready = en;

    for (genvar k = 0; k < N; k++) begin : g_stage
        logic [SLICE-1:0] sa;
        logic [SLICE-1:0] sb;
        logic [SLICE-1:0] sd;
        logic             sbr;
        logic [WIDTH-1:0] prev_d;

        if (k == 0) begin : g_first
            assign sa     = i_a[SLICE-1:0];
            assign sb     = i_b[SLICE-1:0];
            assign sbr    = i_borrow;
            assign prev_d = '0;
        end else begin : g_next
            assign sa     = a_q[k-1][k*SLICE +: SLICE];
            assign sb     = b_q[k-1][k*SLICE +: SLICE];
            assign sbr    = brw_q[k-1];
            assign prev_d = d_q[k-1];
        end

        sub_slice #(
            .W (SLICE)
        ) u_slice (
            .a_i      (sa),
            .b_i      (sb),
            .borrow_i (sbr),
            .diff_o   (sd),
            .borrow_o (brw_d[k])
        );

        // Slices above k are still zero in prev_d, so OR merges the new slice in.
        assign d_d[k] = prev_d | (WIDTH'(sd) << (k * SLICE));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_q <= '0;
            brw_q <= '0;
            for (int k = 0; k < N; k++) begin
                d_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= {vld_q[N-2:0], i_valid};
            brw_q <= brw_d;
            for (int k = 0; k < N; k++) begin
                d_q[k] <= d_d[k];
            end
        end
    end

    // Operand skew registers carry the unresolved upper slices; contents are don't-care when invalid.
    always_ff @(posedge i_clk) begin
        if (en) begin
            a_q[0] <= i_a;
            b_q[0] <= i_b;
            for (int k = 1; k < N - 1; k++) begin
                a_q[k] <= a_q[k-1];
                b_q[k] <= b_q[k-1];
            end
        end
    end

    assign o_valid  = vld_q[N-1];
    assign o_diff   = d_q[N-1];
    assign o_borrow = brw_q[N-1];

endmodule

// File: tb/tb_sub_32b_pipe.sv
// Self-checking bench for sub_32b_pipe: queue-based reference plus directed literal checks.
module tb_sub_32b_pipe;

    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         i_borrow = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b1;
    logic [W-1:0] o_diff;
    logic         o_borrow;

    int vectors     = 0;
    int miscompares = 0;

    logic [W:0] exp_q [$];

    sub_32b_pipe dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_a      (i_a),
        .i_b      (i_b),
        .i_borrow (i_borrow),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_diff   (o_diff),
        .o_borrow (o_borrow)
    );

    always #5 clk = ~clk;

    // Reference: {borrow, diff} from plain 33-bit arithmetic and an unsigned compare.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic br);
        logic [W:0] full;
        logic       lt;
        full = {1'b0, a} - {1'b0, b} - (W+1)'(br);
        lt   = ({1'b0, a} < ({1'b0, b} + (W+1)'(br)));
        return {lt, full[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every cycle, away from the edge, against the reference queue.
    logic         stall_prev = 1'b0;
    logic [W-1:0] prev_diff;
    logic         prev_borrow;
    always @(negedge clk) begin
        logic [W:0] e;
        #2;
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(o_valid), 64'd1);
                check("hold_diff", 64'(o_diff), 64'(prev_diff));
                check("hold_borrow", 64'(o_borrow), 64'(prev_borrow));
            end
            check("o_ready_rule", 64'(o_ready), 64'(!o_valid || i_ready));
            if (o_valid && exp_q.size() == 0) begin
                check("spurious_result", 64'(o_valid), 64'd0);
            end else if (o_valid && i_ready) begin
                e = exp_q.pop_front();
                check("sb_diff", 64'(o_diff), 64'(e[W-1:0]));
                check("sb_borrow", 64'(o_borrow), 64'(e[W]));
            end
            if (i_valid && o_ready) exp_q.push_back(ref_sub(i_a, i_b, i_borrow));
            stall_prev  = o_valid && !i_ready;
            prev_diff   = o_diff;
            prev_borrow = o_borrow;
        end
    end

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic br, input logic [W-1:0] ed, input logic eb);
        int lat;
        bit seen;
        @(negedge clk);
        i_valid = 1'b1; i_a = a; i_b = b; i_borrow = br; i_ready = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat <= 10) begin
            #3;
            if (o_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!seen) begin
            check({nm, "_timeout"}, 64'd0, 64'd1);
        end else begin
            check({nm, "_latency"}, 64'(lat), 64'(LAT));
            check({nm, "_diff"}, 64'(o_diff), 64'(ed));
            check({nm, "_borrow"}, 64'(o_borrow), 64'(eb));
        end
    endtask

    initial begin
        int sent;
        int got;
        int stall;
        bit first;
        int accepted;
        int cyc;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #3;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_diff", 64'(o_diff), 64'd0);
        check("rst_o_borrow", 64'(o_borrow), 64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);

        run_op("five_minus_three", 32'd5, 32'd3, 1'b0, 32'h0000_0002, 1'b0);
        run_op("full_wrap", 32'd0, 32'd1, 1'b0, 32'hFFFF_FFFF, 1'b1);
        run_op("borrow_chain", 32'h0100_0000, 32'd0, 1'b1, 32'h00FF_FFFF, 1'b0);
        run_op("equal_plus_borrow", 32'd7, 32'd7, 1'b1, 32'hFFFF_FFFF, 1'b1);
        run_op("max_minus_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0);
        run_op("msb_boundary", 32'h8000_0000, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0);

        // Eight back-to-back ops with a 3-cycle downstream stall at the first result.
        sent = 0; got = 0; stall = 0; first = 1'b0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            @(negedge clk);
            if (o_valid && !first) begin
                first = 1'b1;
                stall = 3;
            end
            i_ready  = (stall == 0);
            i_valid  = (sent < 8);
            i_a      = 32'(sent) * 32'h0101_0101;
            i_b      = 32'h0000_0003;
            i_borrow = sent[0];
            if (i_valid && (!o_valid || i_ready)) sent++;
            if (o_valid && i_ready) got++;
            if (stall > 0) begin
                #3;
                check("stall_o_ready", 64'(o_ready), 64'd0);
                stall--;
            end
        end
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stall_received", 64'(got), 64'd8);

        // Reset with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            i_valid = 1'b1; i_a = 32'h1234_0000 + 32'(i); i_b = 32'd1; i_borrow = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_valid = 1'b0;
        #3;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #3;
            check("midrst_no_stale", 64'(o_valid), 64'd0);
        end
        run_op("post_reset", 32'h0000_0010, 32'h0000_0001, 1'b1, 32'h0000_000E, 1'b0);

        // Random traffic with random handshakes.
        accepted = 0;
        cyc = 0;
        while (accepted < 10000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: begin i_a = $urandom(); i_b = $urandom(); end
                1: begin i_a = $urandom(); i_b = i_a; end
                2: begin i_a = 32'($urandom_range(0, 3)); i_b = 32'($urandom_range(0, 3)); end
                default: begin
                    i_a = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
                    i_b = $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0;
                end
            endcase
            i_borrow = 1'($urandom_range(0, 1));
            if (i_valid && (!o_valid || i_ready)) accepted++;
        end
        check("random_accepted", 64'(accepted), 64'd10000);
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
